product_accumulator: RTL and testbench
======================================

Name: product_accumulator

Overview:
- Sequential stage directly downstream of the 8x8 unsigned array multiplier; consumes its 16-bit products.
- Sums groups of N_TERMS consecutive products into one ACC_W-bit dot-product result.
- Valid/ready handshakes on both sides; one clock, asynchronous active-low reset.
- Sits between the multiplier output and the result/writeback logic of the MAC datapath.

Parameters:
- N_TERMS, 4: products per group; legal range 1..255.
- ACC_W, 20: accumulator and result width; must be >= 16.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- clear  input  1  synchronous abort; discards any partial group and pending result.
- in_valid  input  1  in_product is valid.
- in_ready  output  1  block can accept a product this cycle.
- in_product  input  16  unsigned product from the multiplier.
- out_valid  output  1  out_sum/out_overflow hold a completed group.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  ACC_W  group sum, modulo 2^ACC_W.
- out_overflow  output  1  group sum exceeded 2^ACC_W-1.
- term_count  output  8  products accepted in the current group.

Behaviour:
- Reset (rst_n=0, asynchronous) clears all state: state=ACC, acc=0, term_count=0, out_sum=0, out_overflow=0, out_valid=0. in_ready=1 after reset is released.
- States:
  - ACC: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accept = in_valid && in_ready (ACC only).
- On accept with term_count < N_TERMS-1:
  - acc <= acc + zero-extended in_product.
  - If term_count==0, acc <= in_product; there is no stale carry between groups.
  - term_count++.
  - Overflow flag ovf sets sticky if the addition carries out of bit ACC_W-1. ovf clears at group start.
- On accept with term_count == N_TERMS-1 (the last term):
  - out_sum <= acc + in_product, and out_overflow <= ovf | carry.
  - acc <= 0, term_count <= 0, state <= DONE.
  - out_valid rises on the next cycle, so latency is 1 cycle from accepting the last product.
- N_TERMS=1: every accepted product goes straight to DONE, with out_sum = product.
- DONE:
  - out_sum and out_overflow stay stable while out_valid && !out_ready.
  - out_valid && out_ready -> state <= ACC. out_valid is 0 and in_ready is 1 on the next cycle.
  - Throughput is N_TERMS+1 cycles per group minimum (one bubble for the handoff).
- in_valid while in_ready=0 is ignored. The upstream must hold the product; no product is lost or duplicated.
- clear=1 has top priority over accept and output handshake:
  - Next state is ACC with acc=0, term_count=0, ovf=0, out_valid=0.
  - out_sum and out_overflow keep their last values (don't-care while out_valid=0).
  - A product presented in the same cycle is dropped.
- Reset asserted mid-group or mid-DONE: immediate return to reset values; the partial group is lost.
- Arithmetic is unsigned only. in_product is zero-extended to ACC_W. The carry out of ACC_W is never stored except as overflow.
- There are no combinational paths from in_valid/out_ready to in_ready/out_valid; in_ready and out_valid decode only from the state register.

Test Plan:
- Default params; feed 10, 20, 30, 40 back-to-back with out_ready=1 -> out_valid pulses 1 cycle after 40 is accepted, out_sum=100, out_overflow=0, term_count returns to 0.
- Feed 65025 four times (255*255) -> out_sum=260100 (0x3F804), out_overflow=0. Then feed 1, 2, 3, 4 -> out_sum=10, showing no carry-over from the prior group.
- Backpressure: complete a group of 5, 5, 5, 5 with out_ready=0 for 6 cycles, in_valid held high with 7 -> in_ready=0, out_sum=20 stable. Release out_ready -> next group begins with 7 and nothing is lost.
- clear: accept 100, 200, then assert clear while presenting 300 -> term_count=0, 300 is dropped. The next group 1, 1, 1, 1 gives out_sum=4.
- ACC_W=17; feed 65025 four times -> out_overflow=1, out_sum=129028 (260100 mod 131072). The next group 1, 1, 1, 1 gives out_overflow=0.
- Pull rst_n low asynchronously mid-group (term_count=2) and in DONE -> all outputs go to zero immediately, in_ready=1 after release, and a fresh group sums correctly.

Source files
------------

// File: rtl/product_accumulator.sv
// Sums groups of N_TERMS unsigned 16-bit products into one ACC_W-bit result with sticky overflow.
// Result is valid 1 cycle after the last product; input stalls (in_ready=0) while a result waits.
module product_accumulator #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_product,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_overflow,
    output logic [7:0]       term_count
);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(N_TERMS - 1);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             out_ovf_q, out_ovf_d;

    logic             accept;
    logic             first_term;
    logic             last_term;
    logic [ACC_W:0]   add_full;
    logic             grp_ovf;

    // Handshake outputs decode only from the state register.
    assign in_ready     = (state_q == ST_ACC);
    assign out_valid    = (state_q == ST_DONE);
    assign out_sum      = sum_q;
    assign out_overflow = out_ovf_q;
    assign term_count   = cnt_q;

    assign accept     = in_valid && in_ready;
    assign first_term = (cnt_q == 8'd0);
    assign last_term  = (cnt_q == LAST_IDX);

    // The first term of a group ignores acc/ovf, so nothing leaks between groups.
    assign add_full = (first_term ? '0 : {1'b0, acc_q}) + (ACC_W + 1)'(in_product);
    assign grp_ovf  = (ovf_q && !first_term) || add_full[ACC_W];

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        out_ovf_d = out_ovf_q;

        if (clear) begin
            state_d = ST_ACC;
            acc_d   = '0;
            cnt_d   = 8'd0;
            ovf_d   = 1'b0;
        end else if (state_q == ST_ACC) begin
            if (accept) begin
                if (last_term) begin
                    sum_d     = add_full[ACC_W-1:0];
                    out_ovf_d = grp_ovf;
                    acc_d     = '0;
                    cnt_d     = 8'd0;
                    ovf_d     = 1'b0;
                    state_d   = ST_DONE;
                end else begin
                    acc_d = add_full[ACC_W-1:0];
                    ovf_d = grp_ovf;
                    cnt_d = cnt_q + 8'd1;
                end
            end
        end else begin
            if (out_ready) begin
                state_d = ST_ACC;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_ACC;
            acc_q     <= '0;
            sum_q     <= '0;
            cnt_q     <= 8'd0;
            ovf_q     <= 1'b0;
            out_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            sum_q     <= sum_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            out_ovf_q <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Drives a 20-bit and a 17-bit accumulator with shared stimulus; a group-sum model feeds per-DUT
// expectation queues that a negedge monitor pops on every output handshake.
module tb_product_accumulator;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic [15:0] in_product;
    logic        out_ready;

    logic        in_ready0, out_valid0, out_overflow0;
    logic [19:0] out_sum0;
    logic [7:0]  term_count0;
    logic        in_ready1, out_valid1, out_overflow1;
    logic [16:0] out_sum1;
    logic [7:0]  term_count1;

    always #5 clk = ~clk;

    product_accumulator #(.N_TERMS(N), .ACC_W(20)) dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready0), .in_product(in_product),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_sum(out_sum0), .out_overflow(out_overflow0), .term_count(term_count0)
    );

    product_accumulator #(.N_TERMS(N), .ACC_W(17)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready1), .in_product(in_product),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_sum(out_sum1), .out_overflow(out_overflow1), .term_count(term_count1)
    );

    typedef struct {
        int unsigned sum;
        bit          ovf;
    } exp_t;

    exp_t q20[$];
    exp_t q17[$];

    int total = 0;
    int bad   = 0;

    int unsigned m_total;
    int          m_cnt;
    bit          m_pend;
    bit          rnd_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: a group is just the plain integer sum of N accepted products.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_total = 0;
            m_cnt   = 0;
            m_pend  = 1'b0;
            q20.delete();
            q17.delete();
        end else if (clear) begin
            m_total = 0;
            m_cnt   = 0;
            m_pend  = 1'b0;
        end else if (m_pend) begin
            if (out_ready) m_pend = 1'b0;
        end else if (in_valid) begin
            m_total += in_product;
            m_cnt++;
            if (m_cnt == N) begin
                q20.push_back('{sum: m_total % (1 << 20), ovf: (m_total >= (1 << 20))});
                q17.push_back('{sum: m_total % (1 << 17), ovf: (m_total >= (1 << 17))});
                m_total = 0;
                m_cnt   = 0;
                m_pend  = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready0", 32'(in_ready0), 32'(!m_pend));
            chk("out_valid0", 32'(out_valid0), 32'(m_pend));
            chk("term_count0", 32'(term_count0), 32'(m_cnt));
            chk("in_ready1", 32'(in_ready1), 32'(!m_pend));
            chk("out_valid1", 32'(out_valid1), 32'(m_pend));
            chk("term_count1", 32'(term_count1), 32'(m_cnt));
            if (out_valid0) begin
                if (q20.size() == 0) begin
                    chk("q20_nonempty", 32'(q20.size()), 32'd1);
                end else begin
                    chk("out_sum0", 32'(out_sum0), q20[0].sum);
                    chk("out_overflow0", 32'(out_overflow0), 32'(q20[0].ovf));
                    if (out_ready || clear) void'(q20.pop_front());
                end
            end
            if (out_valid1) begin
                if (q17.size() == 0) begin
                    chk("q17_nonempty", 32'(q17.size()), 32'd1);
                end else begin
                    chk("out_sum1", 32'(out_sum1), q17[0].sum);
                    chk("out_overflow1", 32'(out_overflow1), 32'(q17[0].ovf));
                    if (out_ready || clear) void'(q17.pop_front());
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that accepts p.
    task automatic send(input logic [15:0] p);
        int n = 0;
        in_valid   = 1'b1;
        in_product = p;
        @(negedge clk);
        while (!in_ready0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL send_timeout product=%0d in_ready actual=0 required=1", p);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic clr_pulse();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_out_sum0"}, 32'(out_sum0), 32'd0);
        chk({tag, "_out_sum1"}, 32'(out_sum1), 32'd0);
        chk({tag, "_out_overflow0"}, 32'(out_overflow0), 32'd0);
        chk({tag, "_out_valid0"}, 32'(out_valid0), 32'd0);
        chk({tag, "_term_count0"}, 32'(term_count0), 32'd0);
        chk({tag, "_in_ready0"}, 32'(in_ready0), 32'd1);
    endtask

    function automatic logic [15:0] rand_prod();
        logic [15:0] v;
        case ($urandom_range(0, 2))
            0:       v = 16'($urandom_range(0, 255));
            1:       v = 16'($urandom_range(0, 65535));
            default: v = 16'($urandom_range(60000, 65535));
        endcase
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        clear      = 1'b0;
        in_valid   = 1'b0;
        in_product = 16'd0;
        out_ready  = 1'b1;
        rnd_done   = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_vals("por");
        idle(1);
        rst_n = 1'b1;
        idle(1);

        // Basic group, then max-product group and a carry-free follow-up.
        send(16'd10); send(16'd20); send(16'd30); send(16'd40);
        idle(2);
        repeat (4) send(16'd65025);
        send(16'd1); send(16'd2); send(16'd3); send(16'd4);
        idle(2);

        // Result held under backpressure while the next product waits.
        out_ready = 1'b0;
        repeat (4) send(16'd5);
        fork
            send(16'd7);
            begin
                repeat (6) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        send(16'd1); send(16'd1); send(16'd1);
        idle(2);

        // Clear drops a coincident product and the partial group.
        send(16'd100); send(16'd200);
        in_valid   = 1'b1;
        in_product = 16'd300;
        clr_pulse();
        in_valid = 1'b0;
        idle(1);
        repeat (4) send(16'd1);
        idle(2);

        // Asynchronous reset mid-group.
        send(16'd1); send(16'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst_mid");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) send(16'd3);
        idle(2);

        // Asynchronous reset while a result is pending.
        out_ready = 1'b0;
        repeat (4) send(16'd9);
        idle(1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst_done");
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(16'd11); send(16'd22); send(16'd33); send(16'd44);
        idle(2);

        // Randomized traffic with random backpressure and occasional clears.
        fork
            begin
                for (int g = 0; g < 200; g++) begin
                    if ($urandom_range(0, 29) == 0) clr_pulse();
                    else send(rand_prod());
                    if ($urandom_range(0, 3) == 0) idle(1);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        idle(10);
        @(negedge clk);
        chk("drain_q20", 32'(q20.size()), 32'd0);
        chk("drain_q17", 32'(q17.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
